// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: decode-mode constants,
// step encoding and the pure transition classifier.
package quad_pkg;

    localparam int MODE_X1 = 1;
    localparam int MODE_X2 = 2;
    localparam int MODE_X4 = 4;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_FWD     = 2'd1,
        STEP_REV     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_t;

    // Place of a {A,B} state on the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] phase_of(input logic [1:0] s);
        case (s)
            2'b00:   phase_of = 2'd0;
            2'b10:   phase_of = 2'd1;
            2'b11:   phase_of = 2'd2;
            default: phase_of = 2'd3;
        endcase
    endfunction

    function automatic step_t classify(input logic [1:0] prev, input logic [1:0] cur,
                                       input int mode);
        logic [1:0] w_delta;
        step_t      w_step;
        w_delta = phase_of(cur) - phase_of(prev);
        case (w_delta)
            2'd1:    w_step = STEP_FWD;
            2'd3:    w_step = STEP_REV;
            2'd2:    w_step = STEP_ILLEGAL;
            default: w_step = STEP_NONE;
        endcase
        // Lower resolutions keep only a subset of the legal steps.
        if (w_step == STEP_FWD || w_step == STEP_REV) begin
            if (mode == MODE_X2 && prev[1] == cur[1])
                w_step = STEP_NONE;
            if (mode == MODE_X1 && !((prev == 2'b00 && cur == 2'b10) ||
                                     (prev == 2'b10 && cur == 2'b00)))
                w_step = STEP_NONE;
        end
        return w_step;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder channel: 2-FF synchroniser followed by a debounce filter that
// accepts a new level after FILTER_LEN consecutive equal tick samples.
module quad_filter
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_pin,
    output logic o_filt
);

    localparam int RUN_W = $clog2(FILTER_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILTER_LEN);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_cand;
    logic             r_filt;
    logic [RUN_W-1:0] r_run;
    logic             w_cand_next;
    logic [RUN_W-1:0] w_run_next;

    always_comb begin
        w_cand_next = r_cand;
        w_run_next  = r_run;
        if (r_sync2 == r_cand) begin
            if (r_run != RUN_MAX)
                w_run_next = r_run + 1'b1;
        end else begin
            w_cand_next = r_sync2;
            w_run_next  = RUN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cand  <= 1'b0;
            r_run   <= '0;
            r_filt  <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (i_tick) begin
                r_cand <= w_cand_next;
                r_run  <= w_run_next;
                if (w_run_next == RUN_MAX)
                    r_filt <= w_cand_next;
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: sample tick, filtered A/B channels, x1/x2/x4
// step decoding into a signed wrapping or saturating position counter.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int SAMPLE_HZ   = 500000,
    parameter int FILTER_LEN  = 3,
    parameter int WIDTH       = 16,
    parameter int MODE        = 4,
    parameter int SATURATE    = 0,
    parameter int INDEX_CLEAR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             canalA,
    input  logic             canalB,
    input  logic             index,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] position,
    output logic             giroPositivo,
    output logic             giroNegativo,
    output logic             direccion,
    output logic             error
);

    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] POS_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (MODE != MODE_X1 && MODE != MODE_X2 && MODE != MODE_X4) begin : g_bad_mode
            $error("quad_decoder: MODE must be 1, 2 or 4");
        end
        if (DIV < 1) begin : g_bad_div
            $error("quad_decoder: CLK_HZ/SAMPLE_HZ must be at least 1");
        end
    endgenerate

    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;
    logic             w_fa;
    logic             w_fb;
    logic [1:0]       w_state;
    logic [1:0]       r_prev;
    step_t            w_step;
    logic             r_idx_s1;
    logic             r_idx_s2;
    logic             r_idx_prev;
    logic             w_idx_rise;
    logic [WIDTH-1:0] r_pos;
    logic [WIDTH-1:0] w_pos_inc;
    logic [WIDTH-1:0] w_pos_dec;
    logic             r_pulse_fwd;
    logic             r_pulse_rev;
    logic             r_dir;
    logic             r_err;

    assign w_tick = (r_tick_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk    (clk),
        .rst    (rst),
        .i_tick (w_tick),
        .i_pin  (canalA),
        .o_filt (w_fa)
    );

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk    (clk),
        .rst    (rst),
        .i_tick (w_tick),
        .i_pin  (canalB),
        .o_filt (w_fb)
    );

    assign w_state    = {w_fa, w_fb};
    assign w_step     = classify(r_prev, w_state, MODE);
    assign w_idx_rise = r_idx_s2 & ~r_idx_prev & (INDEX_CLEAR != 0);

    always_comb begin
        w_pos_inc = r_pos + 1'b1;
        w_pos_dec = r_pos - 1'b1;
        if (SATURATE != 0 && r_pos == POS_MAX)
            w_pos_inc = r_pos;
        if (SATURATE != 0 && r_pos == POS_MIN)
            w_pos_dec = r_pos;
    end

    // prev and the index synchroniser run every clock regardless of enable,
    // so a transition seen while disabled is never replayed later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev      <= 2'b00;
            r_idx_s1    <= 1'b0;
            r_idx_s2    <= 1'b0;
            r_idx_prev  <= 1'b0;
            r_pos       <= '0;
            r_pulse_fwd <= 1'b0;
            r_pulse_rev <= 1'b0;
            r_dir       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_prev      <= w_state;
            r_idx_s1    <= index;
            r_idx_s2    <= r_idx_s1;
            r_idx_prev  <= r_idx_s2;
            r_pulse_fwd <= 1'b0;
            r_pulse_rev <= 1'b0;
            if (clear) begin
                r_pos <= '0;
                r_err <= 1'b0;
            end else begin
                if (enable) begin
                    case (w_step)
                        STEP_FWD: begin
                            r_pulse_fwd <= 1'b1;
                            r_dir       <= 1'b1;
                            r_pos       <= w_pos_inc;
                        end
                        STEP_REV: begin
                            r_pulse_rev <= 1'b1;
                            r_dir       <= 1'b0;
                            r_pos       <= w_pos_dec;
                        end
                        STEP_ILLEGAL: r_err <= 1'b1;
                        default: ;
                    endcase
                end
                // Index wins over the count but not over the pulse/direction.
                if (w_idx_rise)
                    r_pos <= '0;
            end
        end
    end

    assign position     = r_pos;
    assign giroPositivo = r_pulse_fwd;
    assign giroNegativo = r_pulse_rev;
    assign direccion    = r_dir;
    assign error        = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: four instances (x4 wrap, x4 saturate, x2, x1)
// share one set of encoder pins; expected values are hand-computed constants.
module tb_quad_decoder;

    localparam int W = 4;
    localparam int MODE_TAB [4] = '{4, 4, 2, 1};

    logic         clk = 1'b0;
    logic         rst;
    logic         canalA;
    logic         canalB;
    logic         index;
    logic         enable;
    logic         clear;
    logic [W-1:0] pos [4];
    logic         gp  [4];
    logic         gn  [4];
    logic         dir [4];
    logic         err [4];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int lat   = 0;

    int   n_pos  [4] = '{default: 0};
    int   n_neg  [4] = '{default: 0};
    int   n_wide [4] = '{default: 0};
    int   base_pos [4];
    int   base_neg [4];
    logic gp_d [4] = '{default: 1'b0};
    logic gn_d [4] = '{default: 1'b0};

    logic [W-1:0] exp_q [$];

    // Clock / reset-independent cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        quad_decoder #(
            .CLK_HZ      (8),
            .SAMPLE_HZ   (4),
            .FILTER_LEN  (2),
            .WIDTH       (W),
            .MODE        (MODE_TAB[g]),
            .SATURATE    ((g == 1) ? 1 : 0),
            .INDEX_CLEAR (1)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .canalA       (canalA),
            .canalB       (canalB),
            .index        (index),
            .enable       (enable),
            .clear        (clear),
            .position     (pos[g]),
            .giroPositivo (gp[g]),
            .giroNegativo (gn[g]),
            .direccion    (dir[g]),
            .error        (err[g])
        );
    end

    // Pulse monitor: counts pulses and flags any pulse wider than one clock
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (gp[i]) n_pos[i] <= n_pos[i] + 1;
            if (gn[i]) n_neg[i] <= n_neg[i] + 1;
            if ((gp[i] && gp_d[i]) || (gn[i] && gn_d[i])) n_wide[i] <= n_wide[i] + 1;
            gp_d[i] <= gp[i];
            gn_d[i] <= gn[i];
        end
    end

    task automatic check(input string tag, input int i, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_ab(input logic a, input logic b, input int hold);
        canalA = a;
        canalB = b;
        step_clk(hold);
    endtask

    task automatic fwd_cycle();
        drive_ab(1'b1, 1'b0, 8);
        drive_ab(1'b1, 1'b1, 8);
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b0, 1'b0, 8);
    endtask

    task automatic rev_cycle();
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b1, 1'b1, 8);
        drive_ab(1'b1, 1'b0, 8);
        drive_ab(1'b0, 1'b0, 8);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step_clk(1);
        clear = 1'b0;
        step_clk(1);
    endtask

    task automatic snapshot();
        for (int i = 0; i < 4; i++) begin
            base_pos[i] = n_pos[i];
            base_neg[i] = n_neg[i];
        end
    endtask

    task automatic align_even();
        if (cyc % 2 != 0) step_clk(1);
    endtask

    // Scoreboard: expected positions go through exp_q, one per instance
    task automatic expect_pos(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                              input logic [W-1:0] e2, input logic [W-1:0] e3);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
        for (int i = 0; i < 4; i++)
            check(tag, i, 32'(pos[i]), 32'(exp_q.pop_front()));
    endtask

    task automatic check_pulses(input string tag, input int f0, input int f1, input int f2,
                                input int f3, input int r0, input int r1, input int r2,
                                input int r3);
        int ef [4];
        int er [4];
        ef = '{f0, f1, f2, f3};
        er = '{r0, r1, r2, r3};
        for (int i = 0; i < 4; i++) begin
            check({tag, "_fwd_pulses"}, i, n_pos[i] - base_pos[i], ef[i]);
            check({tag, "_rev_pulses"}, i, n_neg[i] - base_neg[i], er[i]);
        end
    endtask

    task automatic check_err(input string tag, input logic e);
        for (int i = 0; i < 4; i++) check(tag, i, 32'(err[i]), 32'(e));
    endtask

    task automatic check_dir(input string tag, input logic e);
        for (int i = 0; i < 4; i++) check(tag, i, 32'(dir[i]), 32'(e));
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_pos"}, i, 32'(pos[i]), 32'd0);
            check({tag, "_gp"},  i, 32'(gp[i]),  32'd0);
            check({tag, "_gn"},  i, 32'(gn[i]),  32'd0);
            check({tag, "_dir"}, i, 32'(dir[i]), 32'd0);
            check({tag, "_err"}, i, 32'(err[i]), 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        canalA = 1'b0;
        canalB = 1'b0;
        index  = 1'b0;
        enable = 1'b1;
        clear  = 1'b0;
        step_clk(3);
        check_all_zero("reset");
        rst = 1'b0;
        step_clk(4);

        // Three forward cycles: x4 wraps 12 -> 4'hC, saturating copy stops at 7
        snapshot();
        repeat (3) fwd_cycle();
        expect_pos("fwd3_pos", 4'hC, 4'h7, 4'h6, 4'h3);
        check_pulses("fwd3", 12, 12, 6, 3, 0, 0, 0, 0);
        check_dir("fwd3_dir", 1'b1);
        check_err("fwd3_err", 1'b0);

        // Clear holds direction; one cycle gives +4/+2/+1, reverse gives -4/-2/-1
        pulse_clear();
        expect_pos("clear_pos", 4'h0, 4'h0, 4'h0, 4'h0);
        check_dir("clear_dir_held", 1'b1);
        fwd_cycle();
        expect_pos("fwd1_pos", 4'h4, 4'h4, 4'h2, 4'h1);
        pulse_clear();
        rev_cycle();
        expect_pos("rev1_pos", 4'hC, 4'hC, 4'hE, 4'hF);
        check_dir("rev1_dir", 1'b0);

        // Two reverse cycles reach -8; three more wrap or hold at min
        pulse_clear();
        repeat (2) rev_cycle();
        expect_pos("rev2_pos", 4'h8, 4'h8, 4'hC, 4'hE);
        pulse_clear();
        snapshot();
        repeat (3) rev_cycle();
        expect_pos("rev3_pos", 4'h4, 4'h8, 4'hA, 4'hD);
        check_pulses("rev3", 0, 0, 0, 0, 12, 12, 6, 3);

        // Single-tick glitch on A is rejected by the filter
        pulse_clear();
        snapshot();
        canalA = 1'b1;
        step_clk(2);
        canalA = 1'b0;
        step_clk(10);
        expect_pos("glitch_pos", 4'h0, 4'h0, 4'h0, 4'h0);
        check_pulses("glitch", 0, 0, 0, 0, 0, 0, 0, 0);

        // Both channels change together: sticky error, then clear
        drive_ab(1'b1, 1'b1, 10);
        check_err("illegal_err", 1'b1);
        expect_pos("illegal_pos", 4'h0, 4'h0, 4'h0, 4'h0);
        step_clk(6);
        check_err("illegal_sticky", 1'b1);
        pulse_clear();
        check_err("clear_err", 1'b0);

        // Disabled: illegal step and forward step are ignored, not replayed
        snapshot();
        enable = 1'b0;
        drive_ab(1'b0, 1'b0, 10);
        drive_ab(1'b1, 1'b0, 10);
        enable = 1'b1;
        step_clk(10);
        check_err("disabled_err", 1'b0);
        expect_pos("disabled_pos", 4'h0, 4'h0, 4'h0, 4'h0);
        check_pulses("disabled", 0, 0, 0, 0, 0, 0, 0, 0);
        enable = 1'b0;
        drive_ab(1'b0, 1'b0, 10);
        enable = 1'b1;
        step_clk(4);

        // Measure pin-to-pulse latency at an even cycle phase
        pulse_clear();
        align_even();
        canalA = 1'b1;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            step_clk(1);
            if (gp[0]) begin
                lat = n;
                break;
            end
        end
        check("latency_in_range", 0, 32'((lat >= 4) && (lat <= 7)), 32'd1);
        if (lat < 4 || lat > 7) lat = 7;
        step_clk(8 - lat);
        drive_ab(1'b1, 1'b1, 8);
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b0, 1'b0, 8);
        expect_pos("pre_index_pos", 4'h4, 4'h4, 4'h2, 4'h1);

        // Index rising edge lands in the same clock as the 00->10 step
        align_even();
        canalA = 1'b1;
        step_clk(lat - 3);
        index = 1'b1;
        step_clk(3);
        expect_pos("index_pos", 4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) check("index_gp", i, 32'(gp[i]), 32'd1);
        check_dir("index_dir", 1'b1);
        step_clk(8);
        index = 1'b0;

        // Walk to position 5 (x4), then reset mid-transition
        drive_ab(1'b1, 1'b1, 8);
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b0, 1'b0, 8);
        drive_ab(1'b1, 1'b0, 8);
        drive_ab(1'b1, 1'b1, 8);
        expect_pos("pre_reset_pos", 4'h5, 4'h5, 4'h2, 4'h1);
        canalA = 1'b0;
        step_clk(2);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        canalA = 1'b0;
        canalB = 1'b0;
        step_clk(3);
        rst = 1'b0;
        snapshot();
        step_clk(12);
        expect_pos("post_reset_pos", 4'h0, 4'h0, 4'h0, 4'h0);
        check_pulses("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        check_err("post_reset_err", 1'b0);

        for (int i = 0; i < 4; i++) check("pulse_width", i, n_wide[i], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Parametrised quadrature encoder decoder; generalises the current fixed 500 Hz direction detector.
- Adds a configurable sample-rate tick, a per-channel debounce filter, and x1/x2/x4 decoding.
- Adds a signed position counter (wrap or saturate), index/clear zeroing, and sticky illegal-transition detection.
- Sits between the board encoder pins and the position and display logic.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
SAMPLE_HZ, 500000, filter sample-tick rate; DIV = CLK_HZ/SAMPLE_HZ, must be >= 1
FILTER_LEN, 3, consecutive equal samples required to accept a new level (>= 1)
WIDTH, 16, position counter width (signed two's complement)
MODE, 4, decode multiplier: 1, 2 or 4; any other value is illegal (elaboration error)
SATURATE, 0, 1 = clamp at signed min/max; 0 = wrap
INDEX_CLEAR, 1, 1 = rising edge of index zeroes position

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
canalA  in  1  encoder channel A (asynchronous pin)
canalB  in  1  encoder channel B (asynchronous pin)
index  in  1  encoder index pulse (asynchronous pin)
enable  in  1  count enable
clear  in  1  synchronous clear of position and error
position  out  WIDTH  signed position
giroPositivo  out  1  one-cycle pulse per forward count
giroNegativo  out  1  one-cycle pulse per reverse count
direccion  out  1  1 = last count forward, 0 = last count reverse
error  out  1  sticky illegal-transition flag

Behaviour:
- Reset: rst=1 asynchronously clears every register: synchronisers, tick counter, filters, prev state, position, pulses, direccion and error.
- Synchronisation: canalA, canalB and index each pass through a 2-FF synchroniser.
- Tick generator: tick is high for one clk every DIV clocks; DIV=1 gives a tick every cycle.
- Filter, per channel, evaluated on tick only:
  - sample == candidate: run increments, saturating at FILTER_LEN.
  - sample != candidate: candidate <= sample, run <= 1.
  - Filtered output <= candidate when run (after update) == FILTER_LEN.
  - FILTER_LEN=1 passes the sample through at each tick.
- State: s = {fA,fB}; prev <= s every clk. Transition is evaluated combinationally on prev != s and registered into outputs at the next edge (1 clk after the filtered change).
- Forward sequence: 00->10->11->01->00. The reverse of each step is -1. Both bits changed is illegal: sets error, no count.
- Mode filtering of legal steps:
  - MODE=4: every step counts.
  - MODE=2: only steps where fA changes.
  - MODE=1: only 00->10 (+1) and 10->00 (-1).
- Counting:
  - +1/-1 on position; the matching giroPositivo/giroNegativo pulses high for exactly the update cycle; direccion updates with it.
  - SATURATE=1: at max, +1 holds position and still emits the pulse; likewise -1 at min.
  - SATURATE=0: two's-complement wrap.
- Priority per cycle, highest first:
  - clear: position=0, error=0, pulses suppressed, direccion held.
  - index rising edge (synchronised, INDEX_CLEAR=1): position=0; pulses and direccion still reflect that cycle's step.
  - Normal step.
- enable=0: filters, prev and tick keep running; no count, no pulses, no error set. Re-enabling never counts stale transitions.
- Latency pin -> position: 2 (sync) + up to DIV*FILTER_LEN (filter) + 1 clk.
- rst mid-transition: all state to 0 immediately; prev=filtered=00, so release produces no spurious count.

Decomposition:
- Package quad_pkg holds:
  - MODE constants (MODE_X1/X2/X4).
  - Step encoding enum STEP_NONE/STEP_FWD/STEP_REV/STEP_ILLEGAL.
  - Pure function classify(prev, cur, mode) returning the step.
- Sub-module quad_filter (2-FF synchroniser plus tick-gated debounce, parameter FILTER_LEN) is instantiated for canalA and canalB; index uses the synchroniser only.
- Tick generator and counter stay in the top module.

Test Plan (CLK_HZ=8, SAMPLE_HZ=4, FILTER_LEN=2, WIDTH=4 unless stated):
1. MODE=4, 3 forward cycles, each level held 4 ticks -> position=12, 12 giroPositivo pulses each 1 clk wide, direccion=1, error=0.
2. MODE=4, from 0, 2 reverse cycles with SATURATE=0 -> position=-8 (4'b1000). SATURATE=1, 3 reverse cycles -> position holds -8, 12 giroNegativo pulses.
3. canalA high for 1 tick only (FILTER_LEN=2) -> filtered unchanged, position=0, no pulses.
4. Filtered 00 -> 11 in one tick -> error=1, position unchanged. Then clear=1 for 1 clk -> error=0, position=0.
5. One forward cycle: MODE=1 -> +1; MODE=2 -> +2; MODE=4 -> +4. Reverse cycle in MODE=1 -> -1.
6. Index rising in the same clk as a forward step -> position=0, giroPositivo pulses. Separately, rst asserted mid-level with position=5 -> all outputs 0 before the next clk edge, and no count after release.
